// File: rtl/branch_resolve_if.sv
// branch_resolve_if: decode-stage branch resolution signals between pipeline/fetch and the resolver
interface branch_resolve_if #(
   parameter int CNT_W = 32
);
   logic             stallD;
   logic             flushD;
   logic             fetch_ready;
   logic             is_branchF;
   logic             predict_takenF;
   logic [31:0]      pc_predictF;
   logic [31:0]      pcF;
   logic [31:0]      instrD;
   logic [31:0]      rs_valueD;
   logic [31:0]      rt_valueD;
   logic             is_branchD;
   logic             branch_takenD;
   logic             mispredictD;
   logic             flush_fetch;
   logic             redirect_valid;
   logic [31:0]      redirect_pc;
   logic [CNT_W-1:0] branch_cnt;
   logic [CNT_W-1:0] mispredict_cnt;

   modport master (
      output stallD, flushD, fetch_ready, is_branchF, predict_takenF, pc_predictF, pcF,
             instrD, rs_valueD, rt_valueD,
      input  is_branchD, branch_takenD, mispredictD, flush_fetch, redirect_valid, redirect_pc,
             branch_cnt, mispredict_cnt
   );

   modport slave (
      input  stallD, flushD, fetch_ready, is_branchF, predict_takenF, pc_predictF, pcF,
             instrD, rs_valueD, rt_valueD,
      output is_branchD, branch_takenD, mispredictD, flush_fetch, redirect_valid, redirect_pc,
             branch_cnt, mispredict_cnt
   );
endinterface

// File: rtl/branch_resolve.sv
// branch_resolve: decode-stage branch outcome, mispredict redirect with hold, and perf counters
module branch_resolve #(
   parameter logic [31:0] FALLTHROUGH_OFFSET = 32'd4,
   parameter int          CNT_W              = 32
) (
   input logic             clk,
   input logic             reset,
   branch_resolve_if.slave bus
);
   typedef enum logic {IDLE, HOLD} state_t;
   state_t           r_state, w_next;
   logic             r_vD, r_predD;
   logic [31:0]      r_tgtD, r_pcD, r_hold_pc;
   logic [CNT_W-1:0] r_branch_cnt, r_mispredict_cnt;
   logic [5:0]       w_op;
   logic [31:0]      w_correct_pc;
   logic             w_eq, w_lez, w_outcome, w_resolve, w_mispredict, w_hold;

   assign w_op         = bus.instrD[31:26];
   assign w_eq         = bus.rs_valueD == bus.rt_valueD;
   assign w_lez        = bus.rs_valueD[31] | (bus.rs_valueD == 32'd0);
   assign w_outcome    = (w_op[1:0] == 2'b00) ? w_eq :
                         (w_op[1:0] == 2'b01) ? ~w_eq :
                         (w_op[1:0] == 2'b10) ? w_lez : ~w_lez;
   assign w_resolve    = r_vD & (w_op[5:2] == 4'b0001) & ~bus.stallD;
   assign w_mispredict = w_resolve & (w_outcome != r_predD);
   assign w_correct_pc = w_outcome ? r_tgtD : r_pcD + FALLTHROUGH_OFFSET;

   assign bus.is_branchD     = w_resolve;
   assign bus.branch_takenD  = w_resolve & w_outcome;
   assign bus.mispredictD    = w_mispredict;
   assign bus.branch_cnt     = r_branch_cnt;
   assign bus.mispredict_cnt = r_mispredict_cnt;

   // F->D prediction register: flush beats stall, stall holds
   always_ff @(posedge clk or posedge reset) begin
      if (reset || bus.flushD) begin
         r_vD    <= 1'b0;
         r_predD <= 1'b0;
         r_tgtD  <= 32'd0;
         r_pcD   <= 32'd0;
      end else if (!bus.stallD) begin
         r_vD    <= bus.is_branchF;
         r_predD <= bus.predict_takenF;
         r_tgtD  <= bus.pc_predictF;
         r_pcD   <= bus.pcF;
      end
   end

   // redirect state and held PC; the newest mispredict always owns hold_pc
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_hold_pc <= 32'd0;
      end else begin
         r_state <= w_next;
         if (w_mispredict) r_hold_pc <= w_correct_pc;
      end
   end

   // redirect next-state and outputs: a fresh mispredict drives the PC combinationally
   always_comb begin
      w_hold             = r_state == HOLD;
      w_next             = ((w_mispredict | w_hold) & ~bus.fetch_ready) ? HOLD : IDLE;
      bus.redirect_valid = w_mispredict | w_hold;
      bus.flush_fetch    = w_mispredict | w_hold;
      bus.redirect_pc    = w_mispredict ? w_correct_pc : w_hold ? r_hold_pc : 32'd0;
   end

   // saturating performance counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_branch_cnt     <= '0;
         r_mispredict_cnt <= '0;
      end else begin
         if (w_resolve && !(&r_branch_cnt)) r_branch_cnt <= r_branch_cnt + 1'b1;
         if (w_mispredict && !(&r_mispredict_cnt)) r_mispredict_cnt <= r_mispredict_cnt + 1'b1;
      end
   end
endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Resolution side of the static-target/2-bit-counter fetch predictor. Sits in the Decode stage.
- Carries each fetch-time prediction across the F->D boundary and evaluates the real BEQ/BNE/BLEZ/BGTZ outcome from forwarded operands.
- Drives the predictor update pair (branch_takenD, is_branchD) exactly once per branch.
- On misprediction, issues the wrong-path flush and a held PC redirect to the sram-like fetch interface. Also keeps saturating branch/mispredict performance counters.

Parameters:
- FALLTHROUGH_OFFSET, 4: byte offset added to branch PC for the not-taken path.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- stallD  in  1  Decode stalled; F->D register holds
- flushD  in  1  Decode flush; F->D register cleared
- fetch_ready  in  1  fetch interface accepts a redirect this cycle
- is_branchF  in  1  predictor branch-detect for the instruction in F
- predict_takenF  in  1  predictor decision for the instruction in F
- pc_predictF  in  32  predicted taken target (branch PC + 4 + sext(offset)<<2)
- pcF  in  32  PC of the instruction in F
- instrD  in  32  instruction in D
- rs_valueD  in  32  forwarded rs operand
- rt_valueD  in  32  forwarded rt operand
- is_branchD  out  1  D holds a branch being resolved this cycle (predictor update enable)
- branch_takenD  out  1  actual outcome
- mispredictD  out  1  actual != predicted, qualified like is_branchD
- flush_fetch  out  1  kill the wrong-path instruction in F
- redirect_valid  out  1  redirect_pc must be used as the next fetch PC
- redirect_pc  out  32  corrected fetch PC
- branch_cnt  out  CNT_W  resolved branches, saturating
- mispredict_cnt  out  CNT_W  mispredictions, saturating

Behaviour:
- F->D register (vD, predD, tgtD, pcD):
  - reset or flushD -> all zero; flushD has priority over stallD.
  - stallD -> hold.
  - otherwise capture is_branchF, predict_takenF, pc_predictF, pcF.
- Opcodes (instrD[31:26]): BEQ 000100, BNE 000101, BLEZ 000110, BGTZ 000111.
- Outcome rules:
  - BEQ taken when rs==rt.
  - BNE taken when rs!=rt.
  - BLEZ taken when rs is signed <= 0.
  - BGTZ taken when rs is signed > 0.
  - Any other opcode is not a branch.
- Resolution, combinational in the D cycle:
  - resolve = vD & opcode-is-branch & ~stallD.
  - is_branchD = resolve; branch_takenD = outcome & resolve; mispredictD = resolve & (outcome != predD).
  - A branch held by stallD for N cycles produces exactly one resolve pulse, on the cycle stallD drops.
- Correct PC:
  - outcome=1 -> tgtD.
  - outcome=0 -> pcD + FALLTHROUGH_OFFSET, 32-bit wrap.
- Redirect FSM, states IDLE and HOLD:
  - IDLE: on mispredictD, assert flush_fetch and redirect_valid, with redirect_pc = correct PC, same cycle (combinational).
    - If fetch_ready=1, stay IDLE.
    - Else latch correct PC into hold_pc and go to HOLD.
  - HOLD: redirect_valid=1, redirect_pc=hold_pc, flush_fetch=1 every cycle. Return to IDLE when fetch_ready=1.
  - A new mispredictD while in HOLD is impossible by construction (stallD is high while fetch is stalled). If it does occur, it overwrites hold_pc (newest wins).
  - flushD while in HOLD does not cancel the redirect.
- Counters:
  - branch_cnt += 1 on resolve; mispredict_cnt += 1 on mispredictD.
  - Both saturate at all-ones, no wrap.
- Reset (asynchronous): FSM IDLE, hold_pc=0, counters=0, F->D register=0. All outputs 0 while reset is asserted and after release until a branch resolves.
- Reset mid-HOLD: redirect is dropped immediately.

Test Plan:
- BEQ with rs=rt=5, predicted not-taken, pcF=0x1000, target 0x1040, fetch_ready=1 -> same D cycle mispredictD=1, flush_fetch=1, redirect_valid=1, redirect_pc=0x1040; branch_cnt=1, mispredict_cnt=1.
- BNE with rs=rt, predicted taken, pcF=0x2000 -> redirect_pc=0x2004, branch_takenD=0, mispredictD=1.
- BGTZ with rs=0x80000000, predicted not-taken -> not taken (signed), mispredictD=0, no redirect; branch_cnt increments.
- Mispredict with fetch_ready=0 for 3 cycles -> redirect_valid and flush_fetch held 4 cycles with constant redirect_pc, FSM returns to IDLE on the cycle fetch_ready=1.
- Branch in D with stallD=1 for 5 cycles -> is_branchD=0 throughout; a single 1-cycle pulse after release; branch_cnt +1 only.
- Preload counters near max (force) then 2 mispredicts -> both saturate at 0xFFFFFFFF. Async reset asserted mid-HOLD -> redirect_valid=0 before the next clk edge.
